// File: rtl/id_seq_if.sv
// id_seq_if: instruction word valid/ready channel into the sequencer.
// master drives words, slave (the sequencer) returns ready.
interface id_seq_if #(
  parameter int INSTR_WIDTH = 8
) ();
  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   instr_ready;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );
endinterface

// File: rtl/id_seq.sv
// id_seq: multi-cycle FETCH/DECODE/OPERAND/EXEC sequencer owning the PC.
// Define ID_SEQ_JZ_EN to make opcode 16 a two-word conditional JZ.
module id_seq #(
  parameter int INSTR_WIDTH = 8,
  parameter int OP_WIDTH    = 8,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  id_seq_if.slave                bus,
  input  logic                   mem_ack,
  input  logic                   zero,
  output logic [OP_WIDTH-1:0]    op,
  output logic                   ldi,
  output logic                   rf_en,
  output logic                   acu_en,
  output logic                   jmp_en,
  output logic                   r_or_w,
  output logic                   sw_rst,
  output logic [INSTR_WIDTH-1:0] imm,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   busy
);

  localparam logic [OP_WIDTH-1:0] OP_NOP = OP_WIDTH'(12);
  localparam logic [OP_WIDTH-1:0] OP_RST = OP_WIDTH'(15);

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    OPERAND,
    EXEC
  } state_e;

  typedef struct packed {
    logic ldi;
    logic rf;
    logic acu;
    logic jmp;
    logic rw;
    logic swr;
    logic jz;
  } strb_t;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [INSTR_WIDTH-1:0] imm_q, imm_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [OP_WIDTH-1:0]    op_q, op_d;
  strb_t                  strb_q, strb_d;

  strb_t                  dec;
  logic [OP_WIDTH-1:0]    dec_op;
  logic                   two_word;
  logic                   is_mem;

  always_comb begin
    dec      = '0;
    dec_op   = OP_WIDTH'(ir_q);
    two_word = 1'b0;
    is_mem   = (ir_q == INSTR_WIDTH'(10)) ||
               (ir_q == INSTR_WIDTH'(11));
    unique case (1'b1)
      (ir_q inside {0, 6, 7, 8, 9}): begin
        dec.acu = 1'b1;
      end
      (ir_q inside {1, 2, 3, 4, 5, 10}): begin
        dec.rf  = 1'b1;
        dec.acu = 1'b1;
      end
      (ir_q == INSTR_WIDTH'(11)): begin
        dec.rf = 1'b1;
        dec.rw = 1'b1;
      end
      (ir_q == INSTR_WIDTH'(12)): begin
        dec_op = OP_NOP;
      end
      (ir_q == INSTR_WIDTH'(13)): begin
        dec.ldi  = 1'b1;
        dec.acu  = 1'b1;
        two_word = 1'b1;
      end
      (ir_q == INSTR_WIDTH'(14)): begin
        dec.jmp  = 1'b1;
        two_word = 1'b1;
      end
`ifdef ID_SEQ_JZ_EN
      (ir_q == INSTR_WIDTH'(16)): begin
        dec.jz   = 1'b1;
        two_word = 1'b1;
      end
`endif
      default: begin
        dec.swr = 1'b1;
        dec_op  = OP_RST;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    op_d    = op_q;
    strb_d  = strb_q;
    unique case (state_q)
      FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (two_word) begin
          state_d = OPERAND;
        end else begin
          state_d = EXEC;
          strb_d  = dec;
          op_d    = dec_op;
        end
      end
      OPERAND: begin
        if (bus.instr_valid) begin
          imm_d   = bus.instr;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = EXEC;
          strb_d  = dec;
          op_d    = dec_op;
        end
      end
      EXEC: begin
        // memory ops park here with strobes held until acked
        if (!is_mem || mem_ack) begin
          state_d = FETCH;
          strb_d  = '0;
          op_d    = OP_NOP;
          if (strb_q.jmp || (strb_q.jz && zero)) begin
            pc_d = ADDR_WIDTH'(imm_q);
          end
          if (strb_q.swr) begin
            pc_d = '0;
          end
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    if (rst) begin
      state_d = FETCH;
      ir_d    = '0;
      imm_d   = '0;
      pc_d    = '0;
      op_d    = OP_NOP;
      strb_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    ir_q    <= ir_d;
    imm_q   <= imm_d;
    pc_q    <= pc_d;
    op_q    <= op_d;
    strb_q  <= strb_d;
  end

  assign bus.instr_ready = (state_q == FETCH) ||
                           (state_q == OPERAND);
  assign busy   = (state_q != FETCH);
  assign op     = op_q;
  assign ldi    = strb_q.ldi;
  assign rf_en  = strb_q.rf;
  assign acu_en = strb_q.acu;
  // JZ looks at zero during its own EXEC cycle
  assign jmp_en = strb_q.jmp | (strb_q.jz & zero);
  assign r_or_w = strb_q.rw;
  assign sw_rst = strb_q.swr;
  assign imm    = imm_q;
  assign pc     = pc_q;

endmodule

// File: tb/tb_id_seq.sv
// tb_id_seq: directed scoreboard bench for the id_seq sequencer.
// Expected EXEC results are queued at issue and popped in EXEC.
module tb_id_seq;

  localparam logic [7:0] NOP = 8'd12;
  localparam logic [7:0] RST = 8'd15;

  typedef struct {
    logic [7:0] op;
    logic [5:0] str;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       mem_ack;
  logic       zero;
  logic [7:0] op;
  logic       ldi, rf_en, acu_en, jmp_en, r_or_w, sw_rst;
  logic [7:0] imm;
  logic [7:0] pc;
  logic       busy;
  logic [5:0] str;

  int n_checks;
  int n_pass;
  int n_fail;
  int ldi_cnt;

  exp_t sb[$];

  id_seq_if #(.INSTR_WIDTH(8)) bus ();

  id_seq #(
    .INSTR_WIDTH(8),
    .OP_WIDTH   (8),
    .ADDR_WIDTH (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .mem_ack(mem_ack),
    .zero   (zero),
    .op     (op),
    .ldi    (ldi),
    .rf_en  (rf_en),
    .acu_en (acu_en),
    .jmp_en (jmp_en),
    .r_or_w (r_or_w),
    .sw_rst (sw_rst),
    .imm    (imm),
    .pc     (pc),
    .busy   (busy)
  );

  assign str = {ldi, rf_en, acu_en, jmp_en, r_or_w, sw_rst};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ldi === 1'b1) ldi_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input string tag, input logic [7:0] w);
    bit ok;
    ok = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr = w;
    for (int i = 0; i < 50; i++) begin
      if (bus.instr_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_op"}, 32'(op), 32'(e.op));
      chk({tag, "_strobes"}, 32'(str), 32'(e.str));
    end
  endtask

  initial begin
    int cnt;
    int ldi0;
    bit all_ok;
    n_checks = 0;
    n_pass = 0;
    n_fail = 0;
    ldi_cnt = 0;
    rst = 1'b1;
    mem_ack = 1'b0;
    zero = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;

    do_reset();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_imm", 32'(imm), 32'h0);
    chk("rst_op", 32'(op), 32'(NOP));
    chk("rst_str", 32'(str), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(bus.instr_ready), 32'h1);

    // ADD: single word
    sb.push_back('{8'd5, 6'b011000});
    send("add", 8'd5);
    @(negedge clk);
    chk("add_dec_busy", 32'(busy), 32'h1);
    chk("add_dec_ready", 32'(bus.instr_ready), 32'h0);
    chk("add_dec_str", 32'(str), 32'h0);
    @(negedge clk);
    pop_chk("add");
    chk("add_pc", 32'(pc), 32'h1);
    @(negedge clk);
    chk("add_done_str", 32'(str), 32'h0);
    chk("add_done_op", 32'(op), 32'(NOP));
    chk("add_done_ready", 32'(bus.instr_ready), 32'h1);

    // LDI with a gapped operand
    do_reset();
    ldi0 = ldi_cnt;
    sb.push_back('{8'd13, 6'b101000});
    send("ldi", 8'd13);
    @(negedge clk);
    all_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!(bus.instr_ready === 1'b1 && busy === 1'b1 &&
            str === 6'b0)) all_ok = 1'b0;
    end
    chk("ldi_operand_wait", 32'(all_ok), 32'h1);
    send("ldi_imm", 8'hA5);
    @(negedge clk);
    pop_chk("ldi");
    chk("ldi_imm", 32'(imm), 32'hA5);
    chk("ldi_pc", 32'(pc), 32'h2);
    @(negedge clk);
    chk("ldi_one_cycle", 32'(ldi_cnt - ldi0), 32'h1);

    // reset while LDI waits for its operand
    ldi0 = ldi_cnt;
    send("ldi2", 8'd13);
    @(negedge clk);
    @(negedge clk);
    chk("ldi2_in_operand", 32'(bus.instr_ready), 32'h1);
    chk("ldi2_pc", 32'(pc), 32'h3);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_pc", 32'(pc), 32'h0);
    chk("abort_imm", 32'(imm), 32'h0);
    chk("abort_op", 32'(op), 32'(NOP));
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_ldi", 32'(ldi_cnt - ldi0), 32'h0);

    // JMP to FE, then JMP across the pc wrap
    do_reset();
    sb.push_back('{8'd14, 6'b000100});
    send("jmp1", 8'd14);
    send("jmp1_imm", 8'hFE);
    @(negedge clk);
    pop_chk("jmp1");
    @(negedge clk);
    chk("jmp1_pc", 32'(pc), 32'hFE);
    sb.push_back('{8'd14, 6'b000100});
    send("jmp2", 8'd14);
    @(negedge clk);
    chk("jmp2_pc_ff", 32'(pc), 32'hFF);
    send("jmp2_imm", 8'h40);
    @(negedge clk);
    pop_chk("jmp2");
    chk("jmp2_pc_wrap", 32'(pc), 32'h00);
    @(negedge clk);
    chk("jmp2_pc", 32'(pc), 32'h40);
    chk("jmp2_str_off", 32'(str), 32'h0);

    // ST held until mem_ack
    do_reset();
    sb.push_back('{8'd11, 6'b010010});
    send("st", 8'd11);
    @(negedge clk);
    cnt = 0;
    all_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rf_en === 1'b1 && r_or_w === 1'b1) begin
        cnt++;
        if (!(busy === 1'b1 && bus.instr_ready === 1'b0))
          all_ok = 1'b0;
        if (cnt == 1) pop_chk("st");
        if (cnt == 5) mem_ack = 1'b1;
      end else begin
        break;
      end
    end
    mem_ack = 1'b0;
    chk("st_cycles", 32'(cnt), 32'd5);
    chk("st_busy_hold", 32'(all_ok), 32'h1);
    chk("st_ready_after", 32'(bus.instr_ready), 32'h1);
    chk("st_busy_after", 32'(busy), 32'h0);

    // illegal opcode, then opcode 16 with zero=1
    do_reset();
    sb.push_back('{RST, 6'b000001});
    send("ill", 8'd20);
    @(negedge clk);
    @(negedge clk);
    pop_chk("ill");
    chk("ill_pc_before", 32'(pc), 32'h1);
    @(negedge clk);
    chk("ill_pulse_end", 32'(sw_rst), 32'h0);
    chk("ill_pc", 32'(pc), 32'h0);
    chk("ill_fetch", 32'(busy), 32'h0);
    zero = 1'b1;
`ifdef ID_SEQ_JZ_EN
    sb.push_back('{8'd16, 6'b000100});
    send("jz", 8'd16);
    send("jz_imm", 8'h10);
    @(negedge clk);
    pop_chk("jz");
    @(negedge clk);
    chk("jz_pc", 32'(pc), 32'h10);
`else
    sb.push_back('{RST, 6'b000001});
    send("jz", 8'd16);
    @(negedge clk);
    @(negedge clk);
    pop_chk("jz");
    chk("jz_pc_before", 32'(pc), 32'h1);
    @(negedge clk);
    chk("jz_pc", 32'(pc), 32'h0);
`endif
    zero = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_seq.md
# id_seq

Multi-cycle instruction sequencer that replaces the single-cycle combinational decoder in the control path. It accepts instruction bytes over a valid/ready handshake, fetches an immediate operand for two-byte instructions, holds memory instructions until acknowledged, and owns the program counter. Its control-strobe outputs feed the register file, accumulator, ALU and jump logic. All strobes are registered and asserted only in the execute state.

## Interface
Parameters:
- INSTR_WIDTH, 8, width of instruction/immediate words; minimum 5
- OP_WIDTH, 8, width of `op` (codes from `instructions.v`)
- ADDR_WIDTH, 8, program counter width

Ports (reset is synchronous and active-high):
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  instruction word available on `instr`
- instr  in  INSTR_WIDTH  opcode or immediate word
- instr_ready  out  1  sequencer accepts a word this cycle
- mem_ack  in  1  data memory has completed an LD/ST
- zero  in  1  accumulator-zero flag (used by JZ)
- op  out  OP_WIDTH  ALU/operation code; `NOP` outside EXEC
- ldi, rf_en, acu_en, jmp_en, r_or_w  out  1 each  control strobes
- sw_rst  out  1  one-cycle software-reset pulse (illegal opcode / RST)
- imm  out  INSTR_WIDTH  latched immediate operand
- pc  out  ADDR_WIDTH  program counter
- busy  out  1  high whenever state is not FETCH

## Operation
- States: FETCH, DECODE, OPERAND, EXEC.
- FETCH: instr_ready=1. On instr_valid, latch `instr` into IR, pc<=pc+1, go to DECODE.
- DECODE: one cycle. Opcodes 13 (LDI), 14 (JMP) and 16 (JZ) go to OPERAND. All other opcodes go to EXEC.
- OPERAND: instr_ready=1. On instr_valid, latch imm, pc<=pc+1, go to EXEC. Otherwise wait indefinitely.
- EXEC: drive strobes for IR, then return to FETCH. For LD/ST, stay in EXEC with strobes held until mem_ack=1.
- Strobe map:
  - 0,6,7,8,9: acu_en
  - 1–5, 10 (LD): rf_en+acu_en
  - 11 (ST): rf_en+r_or_w
  - 12: none
  - 13: ldi+acu_en
  - 14: jmp_en, pc<=imm[ADDR_WIDTH-1:0]
  - 16: jmp_en and pc<=imm only if zero=1; otherwise no strobe
  - 15 and all codes ≥17: sw_rst=1, pc<=0
- `op` carries the matching `instructions.v` code during EXEC (`RST` for the sw_rst cases) and `NOP` in every other state.
- pc wraps modulo 2^ADDR_WIDTH.
- A jump in EXEC overrides any increment; no increment occurs in EXEC.
- instr_ready is 0 in DECODE and EXEC. instr is not sampled in those states.

## Timing
- Reset values: state=FETCH, pc=0, imm=0, op=`NOP`, all strobes 0, sw_rst=0, busy=0, instr_ready=1.
- Reset during any state aborts the instruction in the next cycle, with no strobe emitted after the reset edge.
- Single-word instruction: accepted at edge N, DECODE at N+1, strobes high for cycle N+2, instr_ready=1 again at N+3.
- Two-word instruction: EXEC occurs one cycle after the operand is accepted. The minimum is 4 cycles from opcode to next FETCH.
- LD/ST: if mem_ack is high in the first EXEC cycle, EXEC lasts 1 cycle. Otherwise it lasts until the cycle after mem_ack is sampled high, so strobe duration = 1 + wait cycles.
- sw_rst is exactly one cycle; the sequencer is in FETCH the following cycle with pc=0.
- zero is sampled in the EXEC cycle of JZ only.

## Configuration
- `ID_SEQ_JZ_EN` defined: opcode 16 is JZ (two-word, conditional jump as above).
- Not defined: opcode 16 is illegal. It is single-word, produces sw_rst, and sets pc<=0. OPERAND is entered only for 13 and 14.

## Test plan
- Reset, then opcode 5 with valid held high → rf_en=acu_en=1 in exactly the 3rd cycle after acceptance, op=`ADD`, pc=1.
- Opcodes 13 then immediate 8'hA5, with valid gapped by 3 idle cycles → OPERAND waits; ldi=acu_en=1 for one cycle; imm=8'hA5; pc=2.
- JMP, then 8'h40, starting at pc=8'hFE → pc passes 8'hFF and wraps to 8'h00, then jmp_en=1 and pc=8'h40 after EXEC.
- ST with mem_ack raised 4 cycles into EXEC → rf_en=r_or_w=1 for 5 cycles, busy=1 throughout, instr_ready=0 until FETCH.
- Opcode 8'd20, then opcode 8'd16 with zero=1 and imm 8'h10 → sw_rst pulse with pc=0. Second instruction: with `ID_SEQ_JZ_EN`, jmp_en=1 and pc=8'h10; without it, sw_rst and pc=0.
- Assert rst during OPERAND of LDI → next cycle in FETCH with pc=0, imm=0, no ldi pulse ever emitted.
